// File: rtl/kernel_bc_fifo_pkg.sv
// rtl/kernel_bc_fifo_pkg.sv - shared types and helpers for the kernel_bc FIFO round-robin merger
// The arbiter state encoding and the rotation helper are shared so the pick logic
// can be checked on its own.
package kernel_bc_fifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int RR_MAX_SRC = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // First set request scanning last+1, last+2, ... wrapping at n_src; -1 when none.
  function automatic int next_rr(input logic [RR_MAX_SRC-1:0] req, input int n_src,
                                 input int last);
    int idx;
    int j;
    idx = -1;
    for (int k = n_src; k >= 1; k--) begin
      j = (last + k) % n_src;
      if (req[j]) idx = j;
    end
    return idx;
  endfunction

endpackage

// File: rtl/kernel_bc_fifo_rr_pick.sv
// rtl/kernel_bc_fifo_rr_pick.sv - combinational rotate and priority-encode for the round-robin grant
// Scans req starting one past last; found=0 when nothing is requesting.
module kernel_bc_fifo_rr_pick
  import kernel_bc_fifo_pkg::*;
#(
  parameter int N_SRC    = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [N_SRC-1:0]    req,
  input  logic [ID_WIDTH-1:0] last,
  output logic [ID_WIDTH-1:0] idx,
  output logic                found
);

  int sel;

  always_comb begin
    sel   = next_rr(RR_MAX_SRC'(req), N_SRC, int'(last));
    found = (sel >= 0);
    idx   = found ? ID_WIDTH'(sel) : '0;
  end

endmodule

// File: rtl/kernel_bc_fifo_rr_arb.sv
// rtl/kernel_bc_fifo_rr_arb.sv - round-robin merge of several FIFO read sides into one FIFO write side
// Bursts of up to MAX_BURST beats per grant with a one-cycle arbitration bubble between grants.
module kernel_bc_fifo_rr_arb
  import kernel_bc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_SRC      = 4,
  parameter int ID_WIDTH   = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [N_SRC-1:0]            src_empty_n,
  output logic [N_SRC-1:0]            src_read,
  input  logic [N_SRC*DATA_WIDTH-1:0] src_dout,
  input  logic                        dst_full_n,
  output logic                        dst_write,
  output logic [DATA_WIDTH-1:0]       dst_din,
  output logic [ID_WIDTH-1:0]         dst_id,
  output logic                        busy
);

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_e              state_q;
  logic [ID_WIDTH-1:0] cur_q;
  logic [ID_WIDTH-1:0] last_q;
  logic [7:0]          cnt_q;

  logic [ID_WIDTH-1:0] pick_idx;
  logic                pick_found;
  logic                cur_req;
  logic                beat;
  logic                burst_end;

  kernel_bc_fifo_rr_pick #(
    .N_SRC    (N_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req   (src_empty_n),
    .last  (last_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Data path is a pure mux on cur_q; reset kills the handshake in the same cycle.
  always_comb begin
    busy      = (state_q == ST_GRANT);
    cur_req   = src_empty_n[cur_q];
    beat      = busy & cur_req & dst_full_n & ~reset;
    burst_end = (cnt_q == LAST_BEAT);
    src_read  = '0;
    src_read[cur_q] = beat;
    dst_write = beat;
    dst_id    = busy ? cur_q : '0;
    dst_din   = busy ? src_dout[int'(cur_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      last_q  <= ID_WIDTH'(N_SRC - 1);
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (en && pick_found) begin
            cur_q   <= pick_idx;
            cnt_q   <= '0;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // An empty source releases even while the destination is full.
          if ((beat && burst_end) || !cur_req) begin
            last_q  <= cur_q;
            state_q <= ST_IDLE;
          end else if (beat) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_bc_fifo_rr_arb.sv
// tb/tb_kernel_bc_fifo_rr_arb.sv - scoreboard bench for the round-robin FIFO merger
module tb_kernel_bc_fifo_rr_arb;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           en = 1'b0;
  logic [NS-1:0]  src_empty_n;
  logic [NS-1:0]  src_read;
  logic [NS*DW-1:0] src_dout;
  logic           dst_full_n = 1'b1;
  logic           dst_write;
  logic [DW-1:0]  dst_din;
  logic [IW-1:0]  dst_id;
  logic           busy;

  kernel_bc_fifo_rr_arb #(
    .DATA_WIDTH (DW),
    .N_SRC      (NS),
    .ID_WIDTH   (IW),
    .MAX_BURST  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .src_empty_n (src_empty_n),
    .src_read    (src_read),
    .src_dout    (src_dout),
    .dst_full_n  (dst_full_n),
    .dst_write   (dst_write),
    .dst_din     (dst_din),
    .dst_id      (dst_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    int            b;
    logic          w;
    logic [IW-1:0] id;
    logic [NS-1:0] rd;
  } ctl_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] id;
  } beat_t;

  ctl_t          ctlq[$];
  beat_t         bq[$];
  logic [DW-1:0] sq[NS][$];
  logic [NS-1:0] pm;
  int            mcyc = 0;
  bit            done = 1'b0;
  int            n_vec = 0;
  int            n_fail = 0;
  ctl_t          c;
  beat_t         e;

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      src_empty_n[i] = (sq[i].size() != 0);
      src_dout[i*DW +: DW] = (sq[i].size() != 0) ? sq[i][0] : '0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    pm = src_read;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (pm[i] && sq[i].size() != 0) void'(sq[i].pop_front());
    end
    drive();
  endtask

  // b = -1: busy and dst_id are not checked for that cycle.
  task automatic step(input int b, input logic w, input int id, input logic [NS-1:0] rd);
    ctl_t t;
    t.cyc = mcyc;
    t.b   = b;
    t.w   = w;
    t.id  = IW'(id);
    t.rd  = rd;
    ctlq.push_back(t);
    tick();
  endtask

  task automatic load(input int s, input int base, input int n);
    for (int k = 0; k < n; k++) sq[s].push_back(DW'(base + k));
    drive();
  endtask

  task automatic expb(input int s, input int base, input int n);
    beat_t t;
    for (int k = 0; k < n; k++) begin
      t.d  = DW'(base + k);
      t.id = IW'(s);
      bq.push_back(t);
    end
  endtask

  // Monitor: invariants every cycle, beat scoreboard on writes, per-cycle control checks.
  always @(negedge clk) begin
    if (done) begin
      n_vec++;
      if (bq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover_beats got=%0d exp=0", bq.size());
      end
      n_vec++;
      if (ctlq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover_ctl got=%0d exp=0", ctlq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
    end
    n_vec++;
    if (dst_write && !dst_full_n) begin
      n_fail++;
      $display("FAIL write_while_full cyc=%0d got=1 exp=0", mcyc);
    end
    n_vec++;
    if ((src_read & ~src_empty_n) != '0) begin
      n_fail++;
      $display("FAIL read_while_empty cyc=%0d got=%b exp=0000", mcyc, src_read & ~src_empty_n);
    end
    n_vec++;
    if (!$onehot0(src_read)) begin
      n_fail++;
      $display("FAIL read_onehot cyc=%0d got=%b", mcyc, src_read);
    end
    if (dst_write) begin
      n_vec++;
      if (bq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat cyc=%0d got=%h/%0d exp=none", mcyc, dst_din, dst_id);
      end else begin
        e = bq.pop_front();
        if (dst_din !== e.d || dst_id !== e.id) begin
          n_fail++;
          $display("FAIL beat cyc=%0d got=%h/%0d exp=%h/%0d", mcyc, dst_din, dst_id, e.d, e.id);
        end
      end
    end
    while (ctlq.size() != 0 && ctlq[0].cyc <= mcyc) begin
      c = ctlq.pop_front();
      if (c.b >= 0) begin
        n_vec++;
        if (busy !== 1'(c.b)) begin
          n_fail++;
          $display("FAIL busy cyc=%0d got=%b exp=%b", mcyc, busy, 1'(c.b));
        end
        n_vec++;
        if (dst_id !== c.id) begin
          n_fail++;
          $display("FAIL dst_id cyc=%0d got=%0d exp=%0d", mcyc, dst_id, c.id);
        end
      end
      n_vec++;
      if (dst_write !== c.w) begin
        n_fail++;
        $display("FAIL dst_write cyc=%0d got=%b exp=%b", mcyc, dst_write, c.w);
      end
      n_vec++;
      if (src_read !== c.rd) begin
        n_fail++;
        $display("FAIL src_read cyc=%0d got=%b exp=%b", mcyc, src_read, c.rd);
      end
    end
    mcyc++;
    if (mcyc > 3000) begin
      n_fail++;
      $display("FAIL timeout cyc=%0d", mcyc);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
    end
  end

  initial begin
    drive();
    reset = 1'b1;
    tick();
    step(0, 0, 0, 4'b0000);
    reset = 1'b0;

    // Single requester: 4-beat burst, bubble, then the remaining two beats.
    en = 1'b1;
    load(0, 32'hA0, 6);
    expb(0, 32'hA0, 6);
    step(0, 0, 0, 4'b0000);
    step(1, 1, 0, 4'b0001);
    tick(); tick(); tick();
    step(0, 0, 0, 4'b0000);
    step(1, 1, 0, 4'b0001);
    tick();
    step(1, 0, 0, 4'b0000);
    step(0, 0, 0, 4'b0000);

    // All sources busy after a reset: order 0,1,2,3,0 with a bubble every 5th cycle.
    reset = 1'b1;
    step(0, 0, 0, 4'b0000);
    reset = 1'b0;
    load(0, 32'h100, 8);
    load(1, 32'h200, 4);
    load(2, 32'h300, 4);
    load(3, 32'h400, 4);
    expb(0, 32'h100, 4);
    expb(1, 32'h200, 4);
    expb(2, 32'h300, 4);
    expb(3, 32'h400, 4);
    expb(0, 32'h104, 4);
    for (int g = 0; g < 5; g++) begin
      step(0, 0, 0, 4'b0000);
      for (int b = 0; b < 4; b++) step(1, 1, g % 4, 4'(1 << (g % 4)));
    end
    step(0, 0, 0, 4'b0000);

    // Destination full for 3 cycles in the middle of a burst on source 2.
    load(2, 32'h500, 4);
    expb(2, 32'h500, 4);
    step(0, 0, 0, 4'b0000);
    step(1, 1, 2, 4'b0100);
    step(1, 1, 2, 4'b0100);
    dst_full_n = 1'b0;
    for (int k = 0; k < 3; k++) step(1, 0, 2, 4'b0000);
    dst_full_n = 1'b1;
    step(1, 1, 2, 4'b0100);
    step(1, 1, 2, 4'b0100);
    step(0, 0, 0, 4'b0000);

    // Source 1 runs dry after 2 beats; source 2 wins the next round over 1.
    load(1, 32'h600, 2);
    expb(1, 32'h600, 2);
    step(0, 0, 0, 4'b0000);
    step(1, 1, 1, 4'b0010);
    tick();
    step(1, 0, 1, 4'b0000);
    load(2, 32'h700, 1);
    load(1, 32'h610, 1);
    expb(2, 32'h700, 1);
    expb(1, 32'h610, 1);
    step(0, 0, 0, 4'b0000);
    step(1, 1, 2, 4'b0100);
    step(1, 0, 2, 4'b0000);
    step(0, 0, 0, 4'b0000);
    step(1, 1, 1, 4'b0010);
    step(1, 0, 1, 4'b0000);
    step(0, 0, 0, 4'b0000);

    // en dropped during beat 2: burst completes, then idle until en returns.
    load(2, 32'h800, 4);
    load(3, 32'h900, 2);
    expb(2, 32'h800, 4);
    expb(3, 32'h900, 2);
    step(0, 0, 0, 4'b0000);
    step(1, 1, 2, 4'b0100);
    en = 1'b0;
    step(1, 1, 2, 4'b0100);
    step(1, 1, 2, 4'b0100);
    step(1, 1, 2, 4'b0100);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 4'b0000);
    en = 1'b1;
    step(0, 0, 0, 4'b0000);
    step(1, 1, 3, 4'b1000);
    tick();
    step(1, 0, 3, 4'b0000);
    step(0, 0, 0, 4'b0000);

    // Move last to 0 so that a post-reset grant to source 0 is distinguishable.
    load(0, 32'hA00, 1);
    expb(0, 32'hA00, 1);
    step(0, 0, 0, 4'b0000);
    step(1, 1, 0, 4'b0001);
    step(1, 0, 0, 4'b0000);
    step(0, 0, 0, 4'b0000);

    // Reset pulsed during beat 3 of a burst on source 1.
    load(1, 32'hB00, 4);
    expb(1, 32'hB00, 2);
    step(0, 0, 0, 4'b0000);
    step(1, 1, 1, 4'b0010);
    step(1, 1, 1, 4'b0010);
    reset = 1'b1;
    load(0, 32'hC00, 1);
    step(-1, 0, 0, 4'b0000);
    reset = 1'b0;
    expb(0, 32'hC00, 1);
    expb(1, 32'hB02, 2);
    step(0, 0, 0, 4'b0000);
    step(1, 1, 0, 4'b0001);
    step(1, 0, 0, 4'b0000);
    step(0, 0, 0, 4'b0000);
    step(1, 1, 1, 4'b0010);
    tick();
    step(1, 0, 1, 4'b0000);
    step(0, 0, 0, 4'b0000);

    done = 1'b1;
  end

endmodule
